// File: rtl/vga_sync_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_sync_gen_if
//  Description : Bundle between the VGA timing generator and its consumer.
//                pix_en       - pixel-rate enable into the generator
//                HS, VS       - sync pulses (polarity set by the generator)
//                blank_n      - 1 inside the visible area
//                x, y         - current horizontal / vertical count
//                addr         - linear visible-pixel address
//                line_start   - one-enable pulse when x returns to 0
//                frame_start  - one-enable pulse when (x,y) returns to (0,0)
//                master : the timing generator
//                slave  : the consumer (VGA controller stage)
//  Revision    : 1.0 - initial release
// ============================================================================
interface vga_sync_gen_if;
    logic        pix_en;
    logic        HS;
    logic        VS;
    logic        blank_n;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [18:0] addr;
    logic        line_start;
    logic        frame_start;

    modport master (
        input  pix_en,
        output HS,
        output VS,
        output blank_n,
        output x,
        output y,
        output addr,
        output line_start,
        output frame_start
    );

    modport slave (
        output pix_en,
        input  HS,
        input  VS,
        input  blank_n,
        input  x,
        input  y,
        input  addr,
        input  line_start,
        input  frame_start
    );
endinterface
`default_nettype wire

// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_sync_gen
//  Description : VGA timing generator. Produces HS, VS, blank_n, pixel
//                coordinates and a linear visible-pixel address, advancing
//                once per vga_clk edge on which pix_en is high.
//                Default timing is 640x480@60.
//  Ports       : vga_clk - single clock for all logic
//                reset   - asynchronous, active-high reset
//                bus     - vga_sync_gen_if.master (pix_en in, timing out)
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_gen #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter int unsigned SYNC_POL  = 0
) (
    input  wire logic       vga_clk,
    input  wire logic       reset,
    vga_sync_gen_if.master  bus
);

    localparam int unsigned c_H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned c_V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] c_X_LAST     = 10'(c_H_TOTAL - 1);
    localparam logic [9:0] c_Y_LAST     = 10'(c_V_TOTAL - 1);
    localparam logic [9:0] c_H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0] c_V_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0] c_HS_START   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] c_HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] c_VS_START   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] c_VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic       c_SYNC_ACT   = (SYNC_POL != 0) ? 1'b1 : 1'b0;

    logic [9:0]  r_x;
    logic [9:0]  r_y;
    logic [18:0] r_addr;
    logic        r_hs;
    logic        r_vs;
    logic        r_blank_n;
    logic        r_line_start;
    logic        r_frame_start;

    logic        w_x_wrap;
    logic        w_y_wrap;
    logic [9:0]  w_x_next;
    logic [9:0]  w_y_next;
    logic        w_origin_next;
    logic        w_vis_next;
    logic [18:0] w_addr_next;
    logic        w_hs_next;
    logic        w_vs_next;

    // Every output register is loaded from this single next-position decode,
    // so all outputs always describe the same (x,y).
    always_comb begin
        w_x_wrap      = (r_x == c_X_LAST);
        w_y_wrap      = (r_y == c_Y_LAST);
        w_x_next      = w_x_wrap ? 10'd0 : r_x + 10'd1;
        w_y_next      = r_y;
        if (w_x_wrap) begin
            w_y_next = w_y_wrap ? 10'd0 : r_y + 10'd1;
        end
        w_origin_next = (w_x_next == 10'd0) && (w_y_next == 10'd0);
        w_vis_next    = (w_x_next < c_H_VIS) && (w_y_next < c_V_VIS);

        // Visible pixels are visited in raster order, so the address is a
        // plain counter that freezes across blanking and restarts at (0,0).
        w_addr_next = r_addr;
        if (w_origin_next) begin
            w_addr_next = 19'd0;
        end else if (w_vis_next) begin
            w_addr_next = r_addr + 19'd1;
        end

        w_hs_next = ((w_x_next >= c_HS_START) && (w_x_next < c_HS_END)) ? c_SYNC_ACT : ~c_SYNC_ACT;
        // y only moves on the line wrap, so VS naturally switches with x->0.
        w_vs_next = ((w_y_next >= c_VS_START) && (w_y_next < c_VS_END)) ? c_SYNC_ACT : ~c_SYNC_ACT;
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_x           <= 10'd0;
            r_y           <= 10'd0;
            r_addr        <= 19'd0;
            r_hs          <= ~c_SYNC_ACT;
            r_vs          <= ~c_SYNC_ACT;
            r_blank_n     <= 1'b1;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (bus.pix_en) begin
            r_x           <= w_x_next;
            r_y           <= w_y_next;
            r_addr        <= w_addr_next;
            r_hs          <= w_hs_next;
            r_vs          <= w_vs_next;
            r_blank_n     <= w_vis_next;
            r_line_start  <= w_x_wrap;
            r_frame_start <= w_x_wrap && w_y_wrap;
        end else begin
            // Positions hold; the start pulses last a single cycle only.
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end
    end

    assign bus.x           = r_x;
    assign bus.y           = r_y;
    assign bus.addr        = r_addr;
    assign bus.HS          = r_hs;
    assign bus.VS          = r_vs;
    assign bus.blank_n     = r_blank_n;
    assign bus.line_start  = r_line_start;
    assign bus.frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_sync_gen
//  Description : Self-checking bench for vga_sync_gen. Drives a default
//                640x480 instance and a small 16x7 instance with positive
//                sync polarity side by side, comparing every output each
//                cycle against a position-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_sync_gen;

    // Default timing
    localparam int c_D_HV = 640, c_D_HF = 16, c_D_HS = 96, c_D_HB = 48;
    localparam int c_D_VV = 480, c_D_VF = 10, c_D_VS = 2,  c_D_VB = 33;
    localparam int c_D_TOT = (c_D_HV + c_D_HF + c_D_HS + c_D_HB) * (c_D_VV + c_D_VF + c_D_VS + c_D_VB);
    // Small timing
    localparam int c_S_HV = 8, c_S_HF = 2, c_S_HS = 3, c_S_HB = 3;
    localparam int c_S_VV = 4, c_S_VF = 1, c_S_VS = 1, c_S_VB = 1;
    localparam int c_S_HT  = c_S_HV + c_S_HF + c_S_HS + c_S_HB;
    localparam int c_S_TOT = c_S_HT * (c_S_VV + c_S_VF + c_S_VS + c_S_VB);

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        bn;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [18:0] addr;
        logic        ls;
        logic        fs;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    // Model state: linear position within the frame and whether the last
    // clock edge was an enabled advance.
    int p_d, p_s;
    bit adv_d, adv_s;

    vga_sync_gen_if bus_d ();
    vga_sync_gen_if bus_s ();

    vga_sync_gen u_dut_d (
        .vga_clk (clk),
        .reset   (reset),
        .bus     (bus_d)
    );

    vga_sync_gen #(
        .H_VISIBLE (c_S_HV), .H_FRONT (c_S_HF), .H_SYNC (c_S_HS), .H_BACK (c_S_HB),
        .V_VISIBLE (c_S_VV), .V_FRONT (c_S_VF), .V_SYNC (c_S_VS), .V_BACK (c_S_VB),
        .SYNC_POL  (1)
    ) u_dut_s (
        .vga_clk (clk),
        .reset   (reset),
        .bus     (bus_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Expected outputs at linear frame position p, from the timing rules.
    function automatic exp_t model(input int p, input bit adv,
                                   input int hv, input int hf, input int hsw, input int hb,
                                   input int vv, input int vf, input int vsw, input int vb,
                                   input bit pol);
        int   ht, vt, xx, yy;
        exp_t e;
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        xx = p % ht;
        yy = (p / ht) % vt;
        e.x  = 10'(xx);
        e.y  = 10'(yy);
        e.hs = (xx >= hv + hf && xx < hv + hf + hsw) ? pol : !pol;
        e.vs = (yy >= vv + vf && yy < vv + vf + vsw) ? pol : !pol;
        e.bn = (xx < hv) && (yy < vv);
        // Address of the most recent visible pixel at or before (x,y).
        if (yy < vv) e.addr = 19'(yy * hv + ((xx < hv) ? xx : hv - 1));
        else         e.addr = 19'(hv * vv - 1);
        e.ls = adv && (xx == 0);
        e.fs = adv && (xx == 0) && (yy == 0);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_set(input string name, input exp_t o, input exp_t e);
        chk({name, ".x"},           32'(o.x),    32'(e.x));
        chk({name, ".y"},           32'(o.y),    32'(e.y));
        chk({name, ".addr"},        32'(o.addr), 32'(e.addr));
        chk({name, ".HS"},          32'(o.hs),   32'(e.hs));
        chk({name, ".VS"},          32'(o.vs),   32'(e.vs));
        chk({name, ".blank_n"},     32'(o.bn),   32'(e.bn));
        chk({name, ".line_start"},  32'(o.ls),   32'(e.ls));
        chk({name, ".frame_start"}, 32'(o.fs),   32'(e.fs));
    endtask

    task automatic check_all();
        exp_t od, os;
        od = '{bus_d.HS, bus_d.VS, bus_d.blank_n, bus_d.x, bus_d.y, bus_d.addr,
               bus_d.line_start, bus_d.frame_start};
        os = '{bus_s.HS, bus_s.VS, bus_s.blank_n, bus_s.x, bus_s.y, bus_s.addr,
               bus_s.line_start, bus_s.frame_start};
        chk_set("dflt", od, model(p_d, adv_d, c_D_HV, c_D_HF, c_D_HS, c_D_HB,
                                  c_D_VV, c_D_VF, c_D_VS, c_D_VB, 1'b0));
        chk_set("small", os, model(p_s, adv_s, c_S_HV, c_S_HF, c_S_HS, c_S_HB,
                                   c_S_VV, c_S_VF, c_S_VS, c_S_VB, 1'b1));
    endtask

    // One clock: inputs change on the falling edge, outputs sampled 1 after
    // the rising edge.
    task automatic cyc(input bit rst_v, input bit en_d, input bit en_s);
        @(negedge clk);
        reset        = rst_v;
        bus_d.pix_en = en_d;
        bus_s.pix_en = en_s;
        @(posedge clk);
        if (reset) begin
            p_d = 0; adv_d = 0; p_s = 0; adv_s = 0;
        end else begin
            if (en_d) p_d = (p_d + 1) % c_D_TOT;
            if (en_s) p_s = (p_s + 1) % c_S_TOT;
            adv_d = en_d;
            adv_s = en_s;
        end
        #1;
        check_all();
    endtask

    int hs_low_cnt, ls_cnt, fs_cnt, fs_first, guard;

    initial begin
        checks = 0; failures = 0;
        p_d = 0; p_s = 0; adv_d = 0; adv_s = 0;
        reset = 1'b1;
        bus_d.pix_en = 1'b1;
        bus_s.pix_en = 1'b1;
        #1;
        check_all();

        // Reset held with pix_en high: nothing moves, no pulses.
        repeat (5) cyc(1'b1, 1'b1, 1'b1);

        // First enabled edge after release lands on x=1, addr=1.
        cyc(1'b0, 1'b1, 1'b1);
        chk("first_x",    32'(bus_d.x),    32'd1);
        chk("first_addr", 32'(bus_d.addr), 32'd1);

        // Continuous enable: two default lines, many small frames.
        hs_low_cnt = 0; ls_cnt = 0; fs_cnt = 0;
        for (int i = 0; i < 1700; i++) begin
            cyc(1'b0, 1'b1, 1'b1);
            if (p_d < 800 && bus_d.HS === 1'b0) hs_low_cnt++;
            if (bus_d.line_start === 1'b1) ls_cnt++;
            if (bus_s.frame_start === 1'b1) fs_cnt++;
        end
        chk("hs_width_line0",  32'(hs_low_cnt), 32'(c_D_HS));
        chk("line_start_cnt",  32'(ls_cnt),     32'd2);
        chk("small_frame_cnt", 32'(fs_cnt),     32'((1 + 1700) / c_S_TOT));

        // Alternating enable: outputs hold, pulses stay one cycle wide.
        for (int i = 0; i < 400; i++) begin
            cyc(1'b0, i[0] == 1'b0, i[0] == 1'b0);
        end

        // Random enable patterns.
        for (int i = 0; i < 2000; i++) begin
            cyc(1'b0, 1'($urandom % 2), $urandom_range(0, 3) != 0);
        end

        // Drive the small instance into the middle of the HS and VS pulses.
        guard = 0;
        while (p_s != 5 * c_S_HT + 11 && guard < 300) begin
            cyc(1'b0, 1'b0, 1'b1);
            guard++;
        end
        chk("reach_midpulse", 32'(p_s), 32'(5 * c_S_HT + 11));
        chk("midpulse_hs", 32'(bus_s.HS), 32'd1);
        chk("midpulse_vs", 32'(bus_s.VS), 32'd1);

        // Asynchronous reset between clock edges takes effect at once.
        #1;
        reset = 1'b1;
        #1;
        p_d = 0; adv_d = 0; p_s = 0; adv_s = 0;
        check_all();
        repeat (3) cyc(1'b1, 1'b0, 1'b1);

        // After release the next frame_start comes one full frame later.
        fs_cnt = 0; fs_first = -1;
        for (int i = 0; i < c_S_TOT + 8; i++) begin
            cyc(1'b0, 1'b0, 1'b1);
            if (bus_s.frame_start === 1'b1) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = i + 1;
            end
        end
        chk("restart_fs_cnt",   32'(fs_cnt),   32'd1);
        chk("restart_fs_delay", 32'(fs_first), 32'(c_S_TOT));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
Timing generator for the VGA path. It produces HS, VS, blank_n, pixel coordinates and a linear pixel address from one pixel-rate clock enable. Its outputs feed the VGA controller stage directly: the controller uses blank_n, HS and VS for its address and delay logic and passes the sync pulses to the DAC. Default timing is 640x480@60 (25.175 MHz nominal pixel rate).

Parameters:
H_VISIBLE, 640, active pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, active lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_POL, 0, active level of HS/VS pulses (0 = active-low)

Ports:
vga_clk  in  1  single clock for all logic
reset  in  1  asynchronous, active-high reset
pix_en  in  1  pixel-rate enable; counters advance only when 1 (tie high if vga_clk is the pixel clock)
HS  out  1  horizontal sync, polarity per SYNC_POL
VS  out  1  vertical sync, polarity per SYNC_POL
blank_n  out  1  1 when (x,y) is inside the visible area
x  out  10  horizontal count 0..H_TOTAL-1
y  out  10  vertical count 0..V_TOTAL-1
addr  out  19  linear visible-pixel address, y*H_VISIBLE+x inside the visible area
line_start  out  1  one-enable pulse at x==0
frame_start  out  1  one-enable pulse at x==0,y==0

Behaviour:
- H_TOTAL = sum of the four H_* parameters (800). V_TOTAL = sum of the four V_* parameters (525).
- Reset (asynchronous assert, synchronous-to-clock deassert handled upstream) forces:
  - x=0, y=0, addr=0
  - blank_n=1
  - HS=VS=~SYNC_POL (inactive)
  - line_start=0, frame_start=0
- All outputs are registers. They describe the count held in the same cycle. There is no combinational path from pix_en to any output.
- Counter update on a vga_clk edge with pix_en=1:
  - if x==H_TOTAL-1: x<=0, and then y<=(y==V_TOTAL-1)?0:y+1
  - else x<=x+1
- With pix_en=0, every output holds its value, except that line_start and frame_start drop to 0 after one cycle.
- Horizontal sync is active for H_VISIBLE+H_FRONT <= x < H_VISIBLE+H_FRONT+H_SYNC (656..751).
- Vertical sync is active for V_VISIBLE+V_FRONT <= y < V_VISIBLE+V_FRONT+V_SYNC (490..491). It changes only on the line wrap, aligned with x returning to 0.
- blank_n = (x < H_VISIBLE) && (y < V_VISIBLE).
- addr behaviour:
  - Increments by 1 on each enabled advance where the next position is visible and is not (0,0).
  - Goes to 0 when the next position is (0,0).
  - Holds during blanking.
  - Visible range is 0..307199; it never exceeds H_VISIBLE*V_VISIBLE-1.
- line_start=1 for exactly the cycle in which x becomes 0 from H_TOTAL-1.
- frame_start=1 for exactly the cycle in which (x,y) becomes (0,0) from (H_TOTAL-1,V_TOTAL-1). Neither pulse asserts on reset release.
- The next-state decode (x_next, y_next) drives every output register, so all outputs stay mutually consistent each cycle.
- Reset asserted mid-frame returns to the reset state on the next instant, without waiting for a clock edge. After release, the first enabled edge moves to x=1,y=0.
- Widths: x and y are 10 bits. Parameters must give H_TOTAL and V_TOTAL <= 1024. Any arithmetic overflow is a parameterisation error and is not handled at runtime.

Test Plan:
- Reset held 5 cycles with pix_en=1, then released -> during reset x=y=addr=0, HS=VS=1, blank_n=1, no pulses. First edge after release gives x=1, addr=1.
- pix_en=1 for 800 cycles -> blank_n=1 for x 0..639 and 0 for x 640..799. HS=0 exactly for x 656..751 (96 cycles). line_start=1 only at x=0 of line 1.
- Run one full frame (420000 cycles) -> VS=0 for y=490..491 (1600 cycles). frame_start pulses once at wrap. addr reads 307199 at (639,479), holds through blanking, and reads 0 at (0,0).
- pix_en toggling 1,0,1,0 -> x advances every other cycle, outputs hold while pix_en=0, and line_start width stays 1 cycle. Total frame time is 840000 cycles.
- Assert reset at (x=700,y=491) mid-pulse -> HS and VS go inactive immediately and x=y=0. After release, timing restarts cleanly and the first frame_start occurs 420000 enabled cycles later.
- Overrides H_VISIBLE=8, H_FRONT=2, H_SYNC=3, H_BACK=3, V_VISIBLE=4, V_FRONT=1, V_SYNC=1, V_BACK=1, SYNC_POL=1 -> H_TOTAL=16 and V_TOTAL=7. HS=1 for x 10..12, VS=1 for y=5, and addr runs 0..31.
